// File: rtl/calc_driver.sv
// calc_driver: queues (clr, op, operand) commands and replays each one as a
// timed switch/button sequence into the calculator core, returning its LED value.
module calc_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_clr,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        busy,
  output logic [15:0] calc_sw,
  output logic        calc_btnl,
  output logic        calc_btnc,
  output logic        calc_btnr,
  output logic        calc_btnu,
  output logic        calc_btnd,
  input  logic [15:0] calc_led,
  output logic [1:0]  dbg_state
);

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
  // res_valid is a one-cycle strobe with no backpressure.
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_CW  = PTR_W + 1;
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                         : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_CW-1:0] FULL_CNT  = CNT_CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_CW-1:0]  count_q, count_d;
  logic [19:0]        mem_q [FIFO_DEPTH];
  logic [19:0]        head;
  logic               push, pop;
  logic               cur_clr_q, cur_clr_d;
  logic [15:0]        sw_q, sw_d;
  logic [2:0]         op_q, op_d;
  logic               btnu_q, btnu_d, btnd_q, btnd_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_clr, cmd_op, cmd_data};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_clr_d   = cur_clr_q;
    sw_d        = sw_q;
    op_d        = op_q;
    btnu_d      = btnu_q;
    btnd_d      = btnd_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = SETUP;
          cnt_d     = SETUP_LD;
          cur_clr_d = head[19];
          // A calculator reset leaves the operand and op selection untouched.
          if (!head[19]) begin
            op_d = head[18:16];
            sw_d = head[15:0];
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = PULSE_LD;
          btnu_d  = cur_clr_q;
          btnd_d  = !cur_clr_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
          btnu_d  = 1'b0;
          btnd_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          res_valid_d = 1'b1;
          res_data_d  = calc_led;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_clr_q   <= 1'b0;
      sw_q        <= '0;
      op_q        <= '0;
      btnu_q      <= 1'b0;
      btnd_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_clr_q   <= cur_clr_d;
      sw_q        <= sw_d;
      op_q        <= op_d;
      btnu_q      <= btnu_d;
      btnd_q      <= btnd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign calc_sw   = sw_q;
  assign calc_btnl = op_q[2];
  assign calc_btnc = op_q[1];
  assign calc_btnr = op_q[0];
  assign calc_btnu = btnu_q;
  assign calc_btnd = btnd_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_driver.sv
// Bench for calc_driver: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the command queue and timing.
module tb_calc_driver;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int P     = 2;
  localparam int T     = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_clr;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy;
  logic [15:0] calc_sw;
  logic        calc_btnl, calc_btnc, calc_btnr, calc_btnu, calc_btnd;
  logic [15:0] calc_led;
  logic [1:0]  dbg_state;

  logic        led_mode;   // 1: LED echoes switches, 0: LED shows led_const
  logic [15:0] led_const;
  logic        led_rand = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  int          res_cnt   = 0;
  int          btnu_cnt  = 0;
  int          btnd_cnt  = 0;
  logic [15:0] got_q[$];
  int          rv_cyc[$];

  assign calc_led = led_mode ? calc_sw : led_const;

  calc_driver #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P), .SETTLE_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clr(cmd_clr),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .calc_sw(calc_sw), .calc_btnl(calc_btnl), .calc_btnc(calc_btnc),
    .calc_btnr(calc_btnr), .calc_btnu(calc_btnu), .calc_btnd(calc_btnd),
    .calc_led(calc_led), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (led_rand) led_const = 16'($urandom);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // A command occupies the driver for S+P+T cycles after its pop; the strobe
  // is high for cycles S..S+P-1 of that window and the result appears at its end.
  logic [19:0] mq[$];
  bit          m_active;
  int          m_t;
  logic        m_clr;
  logic [15:0] m_sw;
  logic [2:0]  m_op;
  logic        m_rv;
  logic [15:0] m_rd;

  always @(posedge clk) begin : model
    bit          do_push;
    logic [19:0] hd;
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_t = 0; m_clr = 0; m_sw = '0; m_op = '0; m_rv = 0; m_rd = '0;
    end else begin
      do_push = cmd_valid && (mq.size() < DEPTH);
      m_rv = 0;
      if (m_active) begin
        m_t++;
        if (m_t == S + P + T) begin
          m_active = 0;
          m_rv     = 1;
          m_rd     = led_mode ? m_sw : led_const;
        end
      end else if (mq.size() != 0) begin
        hd       = mq.pop_front();
        m_active = 1;
        m_t      = 0;
        m_clr    = hd[19];
        if (!hd[19]) begin
          m_op = hd[18:16];
          m_sw = hd[15:0];
        end
      end
      if (do_push) mq.push_back({cmd_clr, cmd_op, cmd_data});
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit strobe;
    if (cmp_en) begin
      strobe = m_active && (m_t >= S) && (m_t < S + P);
      check("cmd_ready", cmd_ready, mq.size() < DEPTH);
      check("busy", busy, m_active || (mq.size() != 0));
      check("calc_sw", calc_sw, m_sw);
      check("op_btns", {calc_btnl, calc_btnc, calc_btnr}, m_op);
      check("calc_btnd", calc_btnd, strobe && !m_clr);
      check("calc_btnu", calc_btnu, strobe && m_clr);
      check("res_valid", res_valid, m_rv);
      check("res_data", res_data, m_rd);
      if (res_valid) begin
        res_cnt++;
        got_q.push_back(res_data);
        rv_cyc.push_back(cyc);
      end
      if (calc_btnu) btnu_cnt++;
      if (calc_btnd) btnd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic clr, input logic [2:0] op, input logic [15:0] data,
                      output int acc);
    bit ok;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_clr   = clr;
    cmd_op    = op;
    cmd_data  = data;
    forever begin
      ok = cmd_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 100) begin
        fail_now("send_accept");
        break;
      end
    end
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) fail_now("wait_idle");
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          e0, a, rc0;
    int          acc[6];
    logic [15:0] t6_data[4];
    logic [2:0]  t6_op[4];

    // 1: reset held with a command offered
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_clr = 1'b0; cmd_op = 3'b111; cmd_data = 16'hDEAD;
    led_mode = 1'b0; led_const = 16'h0000;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    check("rst_sw", calc_sw, 16'h0000);
    check("rst_btns", {calc_btnl, calc_btnc, calc_btnr, calc_btnu, calc_btnd}, 5'b0);
    check("rst_res", {res_valid, res_data}, 17'h0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_res_cnt", res_cnt, 0);

    // 2: single command latency
    led_const = 16'hBEEF;
    send(1'b0, 3'b011, 16'h1234, e0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) begin
        check("t2_sw_E1", calc_sw, 16'h1234);
        check("t2_op_E1", {calc_btnl, calc_btnc, calc_btnr}, 3'b011);
      end
      check($sformatf("t2_btnd_E%0d", k), calc_btnd, (k == 3) || (k == 4));
      check($sformatf("t2_rv_E%0d", k), res_valid, k == 8);
      if (k == 8) begin
        check("t2_res_data", res_data, 16'hBEEF);
        check("t2_busy_E8", busy, 1'b0);
      end
    end
    wait_idle();

    // 3: back-to-back commands with a full queue
    led_mode = 1'b1;
    got_q.delete();
    rv_cyc.delete();
    for (int i = 0; i < 6; i++) send(1'b0, 3'(i), 16'hA001 + 16'(i), acc[i]);
    wait_idle();
    for (int i = 1; i < 6; i++) check($sformatf("t3_accept_%0d", i), acc[i] - acc[0], (i < 5) ? i : 10);
    check("t3_res_count", rv_cyc.size(), 6);
    for (int i = 0; i < rv_cyc.size(); i++) begin
      check($sformatf("t3_res_time_%0d", i), rv_cyc[i] - acc[0], 8 * (i + 1));
      check($sformatf("t3_res_order_%0d", i), got_q[i], 16'hA001 + 16'(i));
    end

    // 4: clr command after an operand
    led_mode = 1'b0;
    led_const = 16'h5A5A;
    send(1'b0, 3'b101, 16'h0FF0, a);
    wait_idle();
    btnu_cnt = 0; btnd_cnt = 0; rc0 = res_cnt;
    send(1'b1, 3'b010, 16'hABCD, a);
    wait_idle();
    check("t4_btnu_cycles", btnu_cnt, 2);
    check("t4_btnd_cycles", btnd_cnt, 0);
    check("t4_sw_held", calc_sw, 16'h0FF0);
    check("t4_op_held", {calc_btnl, calc_btnc, calc_btnr}, 3'b101);
    check("t4_res", res_cnt - rc0, 1);

    // 5: reset during STROBE with two commands queued
    send(1'b0, 3'b001, 16'h1111, a);
    send(1'b0, 3'b010, 16'h2222, a);
    send(1'b0, 3'b100, 16'h3333, a);
    begin
      int n;
      n = 0;
      while (!calc_btnd && n < 20) begin
        tick();
        n++;
      end
      if (!calc_btnd) fail_now("t5_strobe");
    end
    rc0 = res_cnt;
    rst_n = 1'b0;
    tick();
    check("t5_btnd", calc_btnd, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", cmd_ready, 1'b1);
    check("t5_rv", res_valid, 1'b0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_no_res", res_cnt - rc0, 0);
    check("t5_idle", busy, 1'b0);

    // 6: echoed LED returns operands in order
    led_mode = 1'b1;
    got_q.delete();
    t6_data = '{16'h324F, 16'h2D31, 16'hFFFF, 16'h7346};
    t6_op   = '{3'b001, 3'b110, 3'b100, 3'b011};
    for (int i = 0; i < 4; i++) send(1'b0, t6_op[i], t6_data[i], a);
    wait_idle();
    check("t6_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("t6_res_%0d", i), got_q[i], t6_data[i]);

    // random traffic
    led_rand = 1'b1;
    rc0 = res_cnt;
    for (int i = 0; i < 40; i++) begin
      led_mode = ($urandom_range(0, 1) == 1);
      send($urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), 16'($urandom), a);
      repeat ($urandom_range(0, 12)) tick();
    end
    wait_idle();
    check("rand_res_count", res_cnt - rc0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
